// File: rtl/plreg_pkg.sv
// plreg_pkg: state encodings and default width shared by the parallel-load register path
package plreg_pkg;
    localparam int DEF_W = 4;
    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
endpackage

// File: rtl/piso_shift_tx_if.sv
// piso_shift_tx_if: load handshake and serial output bundle of the PISO transmitter
interface piso_shift_tx_if #(parameter int W = 4);
    logic [W-1:0] load_data;
    logic         load_valid;
    logic         load_ready;
    logic         ser_en;
    logic         ser_out;
    logic         ser_valid;
    logic         ser_last;
    logic         busy;
    modport master (output load_data, load_valid, ser_en,
                    input  load_ready, ser_out, ser_valid, ser_last, busy);
    modport slave  (input  load_data, load_valid, ser_en,
                    output load_ready, ser_out, ser_valid, ser_last, busy);
endinterface

// File: rtl/piso_bit_cnt.sv
// piso_bit_cnt: down-counter with load, decrement enable and zero flag
module piso_bit_cnt #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_zero
);
    logic [CW-1:0] r_cnt;
    // load wins over decrement; decrement saturates at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else if (i_load) r_cnt <= i_load_val;
        else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in/serial-out transmitter with valid/ready load and shift strobe
module piso_shift_tx
    import plreg_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    piso_shift_tx_if.slave   bus
);
    localparam int CW = $clog2(W);
    state_t         r_state, w_state_nxt;
    logic [W-1:0]   r_shreg, w_shreg_nxt;
    logic           w_zero, w_shift, w_fire, w_dec, w_accept;
    assign w_shift        = (r_state == ST_SHIFT);
    assign w_fire         = w_shift && bus.ser_en;
    assign w_dec          = w_fire && !w_zero;
    assign bus.load_ready = !w_shift || (w_fire && w_zero);
    assign w_accept       = bus.load_valid && bus.load_ready;
    // state and shift register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
        end
    end
    // next state: a new word always enters SHIFT, a consumed last bit without one returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        if (w_accept) w_state_nxt = ST_SHIFT;
        else if (w_fire && w_zero) w_state_nxt = ST_IDLE;
        w_shreg_nxt = w_accept ? bus.load_data :
                      w_dec    ? (MSB_FIRST ? {r_shreg[W-2:0], 1'b0} : {1'b0, r_shreg[W-1:1]}) :
                                 r_shreg;
    end
    piso_bit_cnt #(.CW(CW)) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_accept),
        .i_load_val (CW'(W - 1)),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );
    assign bus.ser_valid = w_shift;
    assign bus.busy      = w_shift;
    assign bus.ser_last  = w_shift && w_zero;
    assign bus.ser_out   = w_shift && (MSB_FIRST ? r_shreg[W-1] : r_shreg[0]);
endmodule
